// File: rtl/exit_uart_reporter_if.sv
// Signal bundle between the SoC exit strobe/value and the exit UART reporter.
// The reporter takes the slave modport; the SoC side (or a bench) takes master.
interface exit_uart_reporter_if;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;
    logic        uart_tx_o;
    logic        busy_o;
    logic        done_o;

    // No handshake back-pressure: the rising edge of exit_valid_i samples exit_value_i
    // once when the reporter is idle; busy_o is high for the whole report, and
    // done_o is sticky from the end of a report until the next capturing edge.
    modport slave (
        input  exit_valid_i,
        input  exit_value_i,
        output uart_tx_o,
        output busy_o,
        output done_o
    );

    modport master (
        output exit_valid_i,
        output exit_value_i,
        input  uart_tx_o,
        input  busy_o,
        input  done_o
    );
endinterface

// File: rtl/exit_uart_reporter.sv
// Sends the 32-bit exit value as 8N1 bytes A5, v[7:0] .. v[31:24] on a rising exit_valid.
// Optional macro EXIT_REPORT_CHECKSUM_EN appends the XOR of those five bytes.
module exit_uart_reporter #(
    parameter int CLK_DIV = 868
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    exit_uart_reporter_if.slave  bus,
    output logic [1:0]           dbg_state_o
);

    localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
`ifdef EXIT_REPORT_CHECKSUM_EN
    localparam int NUM_BYTES = 6;
`else
    localparam int NUM_BYTES = 5;
`endif
    localparam int SHIFT_W = 8 * NUM_BYTES;
    localparam logic [2:0] LAST_BYTE = 3'(NUM_BYTES - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state, r_state_nxt;
    logic                r_valid_q;
    logic [BAUD_W-1:0]   r_baud, r_baud_nxt;
    logic [2:0]          r_bit_cnt, r_bit_cnt_nxt;
    logic [2:0]          r_byte_cnt, r_byte_cnt_nxt;
    logic [SHIFT_W-1:0]  r_shift, r_shift_nxt;
    logic                r_tx, r_tx_nxt;
    logic                r_busy, r_busy_nxt;
    logic                r_done, r_done_nxt;

    logic                w_trigger;
    logic                w_bit_end;
    logic [2:0]          w_bit_inc;
    logic [SHIFT_W-1:0]  w_load;

    assign w_trigger = bus.exit_valid_i & ~r_valid_q;
    assign w_bit_end = (r_baud == BAUD_LAST);
    assign w_bit_inc = r_bit_cnt + 3'd1;

    // The whole frame is latched at once; byte 0 always sits in the low 8 bits.
`ifdef EXIT_REPORT_CHECKSUM_EN
    logic [7:0] w_chk;
    assign w_chk  = SYNC_BYTE ^ bus.exit_value_i[7:0] ^ bus.exit_value_i[15:8]
                  ^ bus.exit_value_i[23:16] ^ bus.exit_value_i[31:24];
    assign w_load = {w_chk, bus.exit_value_i, SYNC_BYTE};
`else
    assign w_load = {bus.exit_value_i, SYNC_BYTE};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_valid_q  <= 1'b1;
            r_baud     <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= r_state_nxt;
            r_valid_q  <= bus.exit_valid_i;
            r_baud     <= r_baud_nxt;
            r_bit_cnt  <= r_bit_cnt_nxt;
            r_byte_cnt <= r_byte_cnt_nxt;
            r_shift    <= r_shift_nxt;
            r_tx       <= r_tx_nxt;
            r_busy     <= r_busy_nxt;
            r_done     <= r_done_nxt;
        end
    end

    // Line level for the next bit is registered on the edge that starts that bit.
    always_comb begin
        r_state_nxt    = r_state;
        r_baud_nxt     = r_baud;
        r_bit_cnt_nxt  = r_bit_cnt;
        r_byte_cnt_nxt = r_byte_cnt;
        r_shift_nxt    = r_shift;
        r_tx_nxt       = r_tx;
        r_busy_nxt     = r_busy;
        r_done_nxt     = r_done;

        if (r_state != S_IDLE) begin
            r_baud_nxt = w_bit_end ? '0 : r_baud + BAUD_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                r_baud_nxt = '0;
                if (w_trigger) begin
                    r_state_nxt    = S_START;
                    r_shift_nxt    = w_load;
                    r_bit_cnt_nxt  = '0;
                    r_byte_cnt_nxt = '0;
                    r_tx_nxt       = 1'b0;
                    r_busy_nxt     = 1'b1;
                    r_done_nxt     = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    r_state_nxt   = S_DATA;
                    r_bit_cnt_nxt = '0;
                    r_tx_nxt      = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 3'd7) begin
                        r_state_nxt = S_STOP;
                        r_tx_nxt    = 1'b1;
                    end else begin
                        r_bit_cnt_nxt = w_bit_inc;
                        r_tx_nxt      = r_shift[w_bit_inc];
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    r_shift_nxt = {8'h00, r_shift[SHIFT_W-1:8]};
                    if (r_byte_cnt == LAST_BYTE) begin
                        r_state_nxt    = S_IDLE;
                        r_byte_cnt_nxt = '0;
                        r_busy_nxt     = 1'b0;
                        r_done_nxt     = 1'b1;
                    end else begin
                        r_state_nxt    = S_START;
                        r_byte_cnt_nxt = r_byte_cnt + 3'd1;
                        r_tx_nxt       = 1'b0;
                    end
                end
            end
            default: r_state_nxt = S_IDLE;
        endcase
    end

    assign bus.uart_tx_o = r_tx;
    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_exit_uart_reporter.sv
// Bench for exit_uart_reporter at CLK_DIV = 4: directed table, random reports, reset corners.
// Build with EXIT_REPORT_CHECKSUM_EN defined to check the six-byte variant.
module tb_exit_uart_reporter;
    localparam int CLK_DIV = 4;
`ifdef EXIT_REPORT_CHECKSUM_EN
    localparam int NUM_BYTES = 6;
`else
    localparam int NUM_BYTES = 5;
`endif

    logic       clk_i;
    logic       rst_i;
    logic [1:0] dbg_state_o;

    exit_uart_reporter_if bus ();

    exit_uart_reporter #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    bit exp_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte list from the frame rules, checksum as XOR of all prior bytes.
    task automatic model_bytes(input logic [31:0] val);
        logic [7:0] chk;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 4; i++) exp_q.push_back(val[8*i +: 8]);
        if (NUM_BYTES == 6) begin
            chk = 8'h00;
            foreach (exp_q[i]) chk = chk ^ exp_q[i];
            exp_q.push_back(chk);
        end
    endtask

    task automatic idle_check(input string tag, input int cycles, input bit done_exp);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk_i);
            check($sformatf("%s_tx[%0d]", tag, k), 32'(bus.uart_tx_o), 32'd1);
            check($sformatf("%s_busy[%0d]", tag, k), 32'(bus.busy_o), 32'd0);
            check($sformatf("%s_done[%0d]", tag, k), 32'(bus.done_o), 32'(done_exp));
        end
    endtask

    // Called at a negedge with exit_valid_i low for at least one prior edge.
    task automatic run_report(input string tag, input logic [31:0] val, input bit noise);
        logic bits[$];
        logic [7:0] b;
        int total;
        while (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            bits.push_back(1'b0);
            for (int j = 0; j < 8; j++) bits.push_back(b[j]);
            bits.push_back(1'b1);
        end
        total = bits.size() * CLK_DIV;
        check({tag, "_pre_done"}, 32'(bus.done_o), 32'(exp_done));
        check({tag, "_pre_busy"}, 32'(bus.busy_o), 32'd0);
        bus.exit_value_i = val;
        bus.exit_valid_i = 1'b1;
        for (int k = 0; k < total; k++) begin
            @(negedge clk_i);
            check($sformatf("%s_tx[%0d]", tag, k), 32'(bus.uart_tx_o), 32'(bits[k / CLK_DIV]));
            check($sformatf("%s_busy[%0d]", tag, k), 32'(bus.busy_o), 32'd1);
            check($sformatf("%s_done[%0d]", tag, k), 32'(bus.done_o), 32'd0);
            if (noise) begin
                if (k < total - 2) begin
                    bus.exit_valid_i = 1'($urandom_range(0, 1));
                    bus.exit_value_i = $urandom;
                end else if (k == total - 2) begin
                    bus.exit_valid_i = 1'b0;
                end else begin
                    // rising edge lands on the final stop-bit edge and must be ignored
                    bus.exit_valid_i = 1'b1;
                end
            end
        end
        @(negedge clk_i);
        check({tag, "_end_busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_end_done"}, 32'(bus.done_o), 32'd1);
        check({tag, "_end_tx"}, 32'(bus.uart_tx_o), 32'd1);
        exp_done = 1'b1;
        idle_check({tag, "_idle"}, 3 * CLK_DIV, 1'b1);
        bus.exit_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic [31:0] value;
        bit          noise;
        logic [47:0] bytes;   // byte i at [8*i +: 8]; top byte is the checksum
    } vec_t;

    vec_t vecs[3];

    initial begin
        vecs[0] = '{name: "basic",  value: 32'hDEADBEEF, noise: 1'b0, bytes: 48'h87_DEADBEEF_A5};
        vecs[1] = '{name: "ignore", value: 32'h00000001, noise: 1'b1, bytes: 48'hA4_00000001_A5};
        vecs[2] = '{name: "repeat", value: 32'h12345678, noise: 1'b0, bytes: 48'hAD_12345678_A5};

        rst_i = 1'b1;
        bus.exit_valid_i = 1'b0;
        bus.exit_value_i = 32'h0;
        @(negedge clk_i);
        check("rst_tx", 32'(bus.uart_tx_o), 32'd1);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        rst_i = 1'b0;
        idle_check("post_rst", 2, 1'b0);

        for (int i = 0; i < 3; i++) begin
            exp_q.delete();
            for (int j = 0; j < NUM_BYTES; j++) exp_q.push_back(vecs[i].bytes[8*j +: 8]);
            run_report(vecs[i].name, vecs[i].value, vecs[i].noise);
        end

        // ---------------- randomized reports ----------------
        for (int i = 0; i < 4; i++) begin
            logic [31:0] v;
            bit nz;
            v  = $urandom;
            nz = 1'($urandom_range(0, 1));
            model_bytes(v);
            run_report($sformatf("rand%0d", i), v, nz);
        end

        // ---------------- reset mid-frame, level held through release ----------------
        bus.exit_value_i = 32'hCAFEF00D;
        bus.exit_valid_i = 1'b1;
        repeat (2 * 10 * CLK_DIV + 3 * CLK_DIV) @(negedge clk_i);
        check("midrst_pre_busy", 32'(bus.busy_o), 32'd1);
        check("midrst_pre_state", 32'(dbg_state_o), 32'd2);
        #1 rst_i = 1'b1;
        #1;
        check("midrst_tx", 32'(bus.uart_tx_o), 32'd1);
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        check("midrst_done", 32'(bus.done_o), 32'd0);
        check("midrst_state", 32'(dbg_state_o), 32'd0);
        exp_done = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        idle_check("level_hold", 15 * CLK_DIV, 1'b0);
        bus.exit_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        model_bytes(32'h0BADC0DE);
        run_report("after_rst", 32'h0BADC0DE, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
